// File: rtl/pc_stack_unit.sv
// Program counter with hold/inc/load/clear plus a LIFO return-address stack for call/ret.
// Overflow and underflow leave out/sp/stack untouched and raise a sticky err flag.
module pc_stack_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned STEP  = 1,
  localparam int unsigned SpW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o,
  output logic [SpW-1:0]   sp_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SpW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             push;
  logic [WIDTH-1:0] next_addr;
  logic [IdxW-1:0]  wr_idx, rd_idx;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign next_addr = out_q + WIDTH'(STEP);
  assign wr_idx    = sp_q[IdxW-1:0];
  assign rd_idx    = IdxW'(sp_q - SpW'(1));

  assign full_o  = (sp_q == SpW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign out_o   = out_q;
  assign sp_o    = sp_q;
  assign err_o   = err_q;

  // Priority: clear > ret > call > load > inc > hold.
  always_comb begin
    out_d = out_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    if (clear_i) begin
      out_d = '0;
      sp_d  = '0;
      err_d = 1'b0;
    end else if (ret_i) begin
      if (empty_o) begin
        err_d = 1'b1;
      end else begin
        out_d = stack_q[rd_idx];
        sp_d  = sp_q - SpW'(1);
      end
    end else if (call_i) begin
      if (full_o) begin
        err_d = 1'b1;
      end else begin
        push  = 1'b1;
        sp_d  = sp_q + SpW'(1);
        out_d = in_i;
      end
    end else if (load_i) begin
      out_d = in_i;
    end else if (inc_i) begin
      out_d = next_addr;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Stack storage needs no reset: entries at or above sp are never read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      stack_q[wr_idx] <= next_addr;
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench: three instances cover the default config, a DEPTH=2 stack and WIDTH=4/STEP=3.
module tb_pc_stack_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Instance A: WIDTH=16, DEPTH=8, STEP=1
  logic        a_rst, a_clear, a_load, a_inc, a_call, a_ret;
  logic [15:0] a_in, a_out;
  logic [3:0]  a_sp;
  logic        a_full, a_empty, a_err;

  // Instance B: WIDTH=16, DEPTH=2, STEP=1
  logic        b_rst, b_clear, b_load, b_inc, b_call, b_ret;
  logic [15:0] b_in, b_out;
  logic [1:0]  b_sp;
  logic        b_full, b_empty, b_err;

  // Instance C: WIDTH=4, DEPTH=8, STEP=3
  logic        c_rst, c_clear, c_load, c_inc, c_call, c_ret;
  logic [3:0]  c_in, c_out;
  logic [3:0]  c_sp;
  logic        c_full, c_empty, c_err;

  pc_stack_unit #(.WIDTH(16), .DEPTH(8), .STEP(1)) u_a (
    .clk_i(clk), .rst_i(a_rst), .clear_i(a_clear), .load_i(a_load), .inc_i(a_inc),
    .call_i(a_call), .ret_i(a_ret), .in_i(a_in), .out_o(a_out), .sp_o(a_sp),
    .full_o(a_full), .empty_o(a_empty), .err_o(a_err)
  );

  pc_stack_unit #(.WIDTH(16), .DEPTH(2), .STEP(1)) u_b (
    .clk_i(clk), .rst_i(b_rst), .clear_i(b_clear), .load_i(b_load), .inc_i(b_inc),
    .call_i(b_call), .ret_i(b_ret), .in_i(b_in), .out_o(b_out), .sp_o(b_sp),
    .full_o(b_full), .empty_o(b_empty), .err_o(b_err)
  );

  pc_stack_unit #(.WIDTH(4), .DEPTH(8), .STEP(3)) u_c (
    .clk_i(clk), .rst_i(c_rst), .clear_i(c_clear), .load_i(c_load), .inc_i(c_inc),
    .call_i(c_call), .ret_i(c_ret), .in_i(c_in), .out_o(c_out), .sp_o(c_sp),
    .full_o(c_full), .empty_o(c_empty), .err_o(c_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    {a_clear, a_load, a_inc, a_call, a_ret} = '0;
  endtask

  task automatic b_idle();
    {b_clear, b_load, b_inc, b_call, b_ret} = '0;
  endtask

  task automatic c_idle();
    {c_clear, c_load, c_inc, c_call, c_ret} = '0;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_idle(); b_idle(); c_idle();
    a_in = '0; b_in = '0; c_in = '0;
    #12;
    chk("a_rst_out", a_out, 0);
    chk("a_rst_sp", a_sp, 0);
    chk("a_rst_empty", a_empty, 1);
    chk("a_rst_full", a_full, 0);
    chk("a_rst_err", a_err, 0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // inc x3
    a_inc = 1'b1;
    tick(); chk("a_inc1", a_out, 16'h0001);
    tick(); chk("a_inc2", a_out, 16'h0002);
    tick(); chk("a_inc3", a_out, 16'h0003);
    a_idle();
    chk("a_inc_sp", a_sp, 0);
    chk("a_inc_empty", a_empty, 1);
    chk("a_inc_err", a_err, 0);

    // single call/ret
    a_load = 1'b1; a_in = 16'h0010;
    tick(); chk("a_load", a_out, 16'h0010);
    a_idle(); a_call = 1'b1; a_in = 16'h0100;
    tick(); chk("a_call_out", a_out, 16'h0100); chk("a_call_sp", a_sp, 1);
    chk("a_call_empty", a_empty, 0);
    a_idle(); a_ret = 1'b1;
    tick(); chk("a_ret_out", a_out, 16'h0011); chk("a_ret_sp", a_sp, 0);
    chk("a_ret_empty", a_empty, 1);

    // nested calls
    a_idle(); a_load = 1'b1; a_in = 16'h0005;
    tick();
    a_idle(); a_call = 1'b1; a_in = 16'h0100; tick();
    a_in = 16'h0200; tick();
    a_in = 16'h0300; tick();
    chk("a_nest_out", a_out, 16'h0300); chk("a_nest_sp", a_sp, 3);
    a_idle(); a_ret = 1'b1;
    tick(); chk("a_nret1", a_out, 16'h0201);
    tick(); chk("a_nret2", a_out, 16'h0101);
    tick(); chk("a_nret3", a_out, 16'h0006); chk("a_nret_sp", a_sp, 0);
    a_idle();
    tick(); chk("a_hold", a_out, 16'h0006);

    // underflow, sticky err, call+ret+load
    a_ret = 1'b1;
    tick(); chk("a_uf_out", a_out, 16'h0006); chk("a_uf_err", a_err, 1);
    a_idle(); a_load = 1'b1; a_in = 16'h0007;
    tick(); chk("a_load7", a_out, 16'h0007); chk("a_sticky", a_err, 1);
    a_call = 1'b1; a_ret = 1'b1; a_in = 16'h1234;
    tick(); chk("a_crl_out", a_out, 16'h0007); chk("a_crl_sp", a_sp, 0);
    chk("a_crl_err", a_err, 1);
    a_idle(); a_clear = 1'b1; a_ret = 1'b1;
    tick(); chk("a_clr_out", a_out, 0); chk("a_clr_err", a_err, 0);
    a_idle(); a_call = 1'b1; a_load = 1'b1; a_in = 16'h0040;
    tick(); chk("a_cl_out", a_out, 16'h0040); chk("a_cl_sp", a_sp, 1);
    a_idle(); a_ret = 1'b1;
    tick(); chk("a_cl_ret", a_out, 16'h0001);
    a_idle();

    // DEPTH=2 overflow
    b_load = 1'b1; b_in = 16'h0020;
    tick();
    b_idle(); b_call = 1'b1; b_in = 16'h0100;
    tick(); chk("b_c1_sp", b_sp, 1);
    b_in = 16'h0200;
    tick(); chk("b_c2_out", b_out, 16'h0200); chk("b_full", b_full, 1);
    b_in = 16'h0ABC;
    tick(); chk("b_of_out", b_out, 16'h0200); chk("b_of_sp", b_sp, 2);
    chk("b_of_err", b_err, 1);
    b_idle(); b_inc = 1'b1;
    tick(); chk("b_inc_out", b_out, 16'h0201); chk("b_inc_err", b_err, 1);
    b_idle(); b_ret = 1'b1;
    tick(); chk("b_ret_out", b_out, 16'h0101); chk("b_ret_sp", b_sp, 1);
    b_idle(); b_clear = 1'b1;
    tick(); chk("b_clr_out", b_out, 0); chk("b_clr_sp", b_sp, 0);
    chk("b_clr_err", b_err, 0); chk("b_clr_full", b_full, 0);
    chk("b_clr_empty", b_empty, 1);
    b_idle();

    // WIDTH=4, STEP=3 wrap and mid-cycle reset
    c_load = 1'b1; c_in = 4'hE;
    tick();
    c_idle(); c_inc = 1'b1;
    tick(); chk("c_wrap", c_out, 4'h1); chk("c_wrap_err", c_err, 0);
    c_idle(); c_load = 1'b1; c_in = 4'hE;
    tick();
    c_idle(); c_call = 1'b1; c_in = 4'h2;
    tick(); chk("c_call_out", c_out, 4'h2);
    c_idle(); c_ret = 1'b1;
    tick(); chk("c_ret_wrap", c_out, 4'h1);
    c_idle(); c_call = 1'b1; c_in = 4'h5;
    tick();
    c_in = 4'h9;
    tick(); chk("c_2call_sp", c_sp, 2); chk("c_2call_out", c_out, 4'h9);
    #2 c_rst = 1'b1;
    #1;
    chk("c_arst_out", c_out, 0); chk("c_arst_sp", c_sp, 0);
    chk("c_arst_empty", c_empty, 1); chk("c_arst_err", c_err, 0);
    #2 c_rst = 1'b0;
    c_idle(); c_inc = 1'b1;
    tick(); chk("c_post_rst", c_out, 4'h3); chk("c_post_sp", c_sp, 0);
    c_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
